// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a req/ack data-memory bus for loads and stores,
// stalls upstream while an access is outstanding, and registers the MEM/WB result.
module mem_access_stage #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              mem_read_n2,
   input  logic              mem_write_n2,
   input  logic              mem_to_reg_n2,
   input  logic [DATA_W-1:0] alu_out_n,
   input  logic [DATA_W-1:0] rs2_data_n,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              mem_to_reg_n3,
   output logic [DATA_W-1:0] alu_out_n3,
   output logic [DATA_W-1:0] read_data_n3,
   output logic              mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dmem_req_q, dmem_req_d;
   logic                dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic                lat_m2r_q, lat_m2r_d;
   logic                lat_load_q, lat_load_d;
   logic [DATA_W-1:0]   lat_alu_q, lat_alu_d;
   logic                wb_valid_q, wb_valid_d;
   logic                mem_to_reg_n3_q, mem_to_reg_n3_d;
   logic [DATA_W-1:0]   alu_out_n3_q, alu_out_n3_d;
   logic [DATA_W-1:0]   read_data_n3_q, read_data_n3_d;
   logic                mem_err_q, mem_err_d;
   logic                stall_c;
   logic                is_op;
   logic                bad_op;

   assign is_op  = mem_read_n2 | mem_write_n2;
   assign bad_op = (mem_read_n2 & mem_write_n2) | (alu_out_n[1:0] != 2'b00);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      dmem_req_d      = dmem_req_q;
      dmem_we_d       = dmem_we_q;
      dmem_addr_d     = dmem_addr_q;
      dmem_wdata_d    = dmem_wdata_q;
      lat_m2r_d       = lat_m2r_q;
      lat_load_d      = lat_load_q;
      lat_alu_d       = lat_alu_q;
      wb_valid_d      = 1'b0;
      mem_err_d       = 1'b0;
      mem_to_reg_n3_d = mem_to_reg_n3_q;
      alu_out_n3_d    = alu_out_n3_q;
      read_data_n3_d  = read_data_n3_q;
      stall_c         = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!is_op) begin
                  wb_valid_d      = 1'b1;
                  alu_out_n3_d    = alu_out_n;
                  mem_to_reg_n3_d = mem_to_reg_n2;
                  read_data_n3_d  = '0;
               end else if (bad_op) begin
                  mem_err_d = 1'b1;
               end else begin
                  stall_c      = 1'b1;
                  state_d      = BUSY;
                  cnt_d        = '0;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = mem_write_n2;
                  dmem_addr_d  = alu_out_n[ADDR_W-1:0];
                  dmem_wdata_d = rs2_data_n;
                  lat_m2r_d    = mem_to_reg_n2;
                  lat_load_d   = mem_read_n2;
                  lat_alu_d    = alu_out_n;
               end
            end
         end
         BUSY: begin
            stall_c = !dmem_ack;
            // An ack arriving on the final allowed cycle still completes normally.
            if (dmem_ack) begin
               state_d         = IDLE;
               dmem_req_d      = 1'b0;
               wb_valid_d      = 1'b1;
               alu_out_n3_d    = lat_alu_q;
               mem_to_reg_n3_d = lat_m2r_q;
               read_data_n3_d  = lat_load_q ? dmem_rdata : '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d    = IDLE;
               dmem_req_d = 1'b0;
               mem_err_d  = 1'b1;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= '0;
         dmem_wdata_q    <= '0;
         lat_m2r_q       <= 1'b0;
         lat_load_q      <= 1'b0;
         lat_alu_q       <= '0;
         wb_valid_q      <= 1'b0;
         mem_to_reg_n3_q <= 1'b0;
         alu_out_n3_q    <= '0;
         read_data_n3_q  <= '0;
         mem_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         dmem_req_q      <= dmem_req_d;
         dmem_we_q       <= dmem_we_d;
         dmem_addr_q     <= dmem_addr_d;
         dmem_wdata_q    <= dmem_wdata_d;
         lat_m2r_q       <= lat_m2r_d;
         lat_load_q      <= lat_load_d;
         lat_alu_q       <= lat_alu_d;
         wb_valid_q      <= wb_valid_d;
         mem_to_reg_n3_q <= mem_to_reg_n3_d;
         alu_out_n3_q    <= alu_out_n3_d;
         read_data_n3_q  <= read_data_n3_d;
         mem_err_q       <= mem_err_d;
      end
   end

   // Stall is gated by reset so it reads 0 while reset is held, even with a valid op presented.
   assign stall         = stall_c & reset;
   assign dmem_req      = dmem_req_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign wb_valid      = wb_valid_q;
   assign mem_to_reg_n3 = mem_to_reg_n3_q;
   assign alu_out_n3    = alu_out_n3_q;
   assign read_data_n3  = read_data_n3_q;
   assign mem_err       = mem_err_q;

endmodule
